// File: rtl/bam_seq_mult_if.sv
// Valid/ready stream bundle for bam_seq_mult: operand/config beat in, approximate product out.
interface bam_seq_mult_if #(
  parameter int N  = 8,
  parameter int HW = $clog2(N + 1),
  parameter int VW = $clog2(2 * N)
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic [HW-1:0]  cfg_h;
  logic [VW-1:0]  cfg_v;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] p;
  logic           busy;

  modport master (
    output in_valid, a, b, cfg_h, cfg_v, out_ready,
    input  in_ready, out_valid, p, busy
  );

  modport slave (
    input  in_valid, a, b, cfg_h, cfg_v, out_ready,
    output in_ready, out_valid, p, busy
  );
endinterface

// File: rtl/bam_seq_mult.sv
// Sequential broken-array approximate unsigned multiplier: one partial-product row per clock,
// rows below cfg_h and columns below cfg_v are dropped; cfg_h = cfg_v = 0 is exact.
module bam_seq_mult #(
  parameter int N  = 8,
  parameter int HW = $clog2(N + 1),
  parameter int VW = $clog2(2 * N)
) (
  input logic           clk,
  input logic           rst,
  bam_seq_mult_if.slave bus
);
  localparam int            IW     = $clog2(N);
  localparam logic [HW-1:0] H_MAX  = HW'(N);
  localparam logic [HW-1:0] J_LAST = HW'(N - 1);
  localparam logic [VW-1:0] V_MAX  = VW'(2 * N - 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e         state_q;
  logic [N-1:0]   a_q, b_q;
  logic [VW-1:0]  v_q;
  logic [HW-1:0]  j_q;
  logic [2*N-1:0] acc_q, acc_d, p_q;
  logic           in_ready_q, out_valid_q, busy_q;

  logic [HW-1:0]  h_start;
  logic [VW-1:0]  v_eff;
  logic [N-1:0]   row_keep;
  logic [2*N-1:0] row_pp;

  // Oversized breaks saturate: cfg_h beyond N drops every row, cfg_v beyond 2N-2 keeps the top bit eligible.
  always_comb begin
    h_start = (bus.cfg_h > H_MAX) ? H_MAX : bus.cfg_h;
    v_eff   = (bus.cfg_v > V_MAX) ? V_MAX : bus.cfg_v;
  end

  // NOTE: every signal written here gets a value before any conditional use, so no latch is inferred.
  always_comb begin
    row_keep = '0;
    for (int i = 0; i < N; i++) begin
      row_keep[i] = (i + int'(j_q)) >= int'(v_q);
    end
    row_pp = {{N{1'b0}}, a_q & row_keep & {N{b_q[j_q[IW-1:0]]}}} << j_q;
    acc_d  = acc_q + row_pp;
  end

  // NOTE: state is updated with non-blocking assignments only, so every read in this block sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: datapath registers are reset too, because p must read 0 straight out of reset.
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      v_q         <= '0;
      j_q         <= '0;
      acc_q       <= '0;
      p_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            v_q        <= v_eff;
            j_q        <= h_start;
            acc_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (h_start == H_MAX) begin
              state_q     <= DONE;
              p_q         <= '0;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          acc_q <= acc_d;
          j_q   <= j_q + 1'b1;
          if (j_q == J_LAST) begin
            state_q     <= DONE;
            p_q         <= acc_d;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.p         = p_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_bam_seq_mult.sv
// Scoreboard bench for bam_seq_mult: directed and random checks at N=8, random regression at N=4 and N=16.
module tb_bam_seq_mult;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst8;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  bam_seq_mult_if #(.N(N)) if8 ();
  bam_seq_mult #(.N(N)) dut8 (.clk(clk), .rst(rst8), .bus(if8));
  logic [2*N-1:0] sb8[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Golden BAM array: sum of a[i]&b[j] << (i+j) over retained bits, with cfg_v saturated at 2n-2.
  function automatic logic [63:0] bam_model(input logic [31:0] a, input logic [31:0] b,
                                            input int h, input int v, input int n);
    logic [63:0] s;
    int vv;
    s  = '0;
    vv = (v > 2 * n - 2) ? 2 * n - 2 : v;
    for (int j = 0; j < n; j++)
      for (int i = 0; i < n; i++)
        if (j >= h && i + j >= vv && a[i] && b[j]) s += 64'(1) << (i + j);
    return s;
  endfunction

  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic [3:0] h,
                         input logic [3:0] v, input logic [15:0] exp, input int hold,
                         input bit scramble, input string tag);
    int t, lat, runs, hs;
    hs = (int'(h) > N) ? N : int'(h);
    @(negedge clk);
    if8.a = a; if8.b = b; if8.cfg_h = h; if8.cfg_v = v; if8.in_valid = 1'b1;
    t = 0;
    while (!if8.in_ready && t < 50) begin @(negedge clk); t++; end
    check({tag, " accept"}, 64'(t < 50), 64'(1));
    sb8.push_back(exp);
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    @(negedge clk);
    lat = 1; runs = 0;
    while (!if8.out_valid && lat < 60) begin
      if (if8.busy) runs++;
      if (scramble && runs == 2) begin
        if8.a = 8'($urandom); if8.b = 8'($urandom);
        if8.cfg_h = 4'($urandom); if8.cfg_v = 4'($urandom);
      end
      @(negedge clk); lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(N - hs + 1));
    check({tag, " run_cycles"}, 64'(runs), 64'(N - hs));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({tag, " bp_p"}, 64'(if8.p), 64'(exp));
      check({tag, " bp_out_valid"}, 64'(if8.out_valid), 64'(1));
      check({tag, " bp_in_ready"}, 64'(if8.in_ready), 64'(0));
    end
    check({tag, " p"}, 64'(if8.p), 64'(sb8.pop_front()));
    if8.out_ready = 1'b1;
    @(posedge clk); #1;
    if8.out_ready = 1'b0;
    @(negedge clk);
    check({tag, " post_out_valid"}, 64'(if8.out_valid), 64'(0));
    check({tag, " post_in_ready"}, 64'(if8.in_ready), 64'(1));
    check({tag, " post_p_held"}, 64'(if8.p), 64'(exp));
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_reg
    localparam int NN  = (g == 0) ? 4 : 16;
    localparam int HWN = $clog2(NN + 1);
    localparam int VWN = $clog2(2 * NN);
    logic rst_g;
    bit   done = 1'b0;
    bam_seq_mult_if #(.N(NN)) ifr ();
    bam_seq_mult #(.N(NN)) dut (.clk(clk), .rst(rst_g), .bus(ifr));
    logic [2*NN-1:0] sbq[$];

    initial begin
      logic [NN-1:0] ra, rb;
      int t;
      ifr.in_valid = 1'b0; ifr.out_ready = 1'b0;
      ifr.a = '0; ifr.b = '0; ifr.cfg_h = '0; ifr.cfg_v = '0;
      rst_g = 1'b1;
      repeat (2) @(negedge clk);
      rst_g = 1'b0;
      for (int h = 0; h < 2 ** HWN; h++)
        for (int v = 0; v < 2 ** VWN; v++)
          for (int r = 0; r < ((NN == 4) ? 4 : 1); r++) begin
            ra = NN'($urandom); rb = NN'($urandom);
            @(negedge clk);
            ifr.a = ra; ifr.b = rb; ifr.cfg_h = HWN'(h); ifr.cfg_v = VWN'(v); ifr.in_valid = 1'b1;
            t = 0;
            while (!ifr.in_ready && t < 50) begin @(negedge clk); t++; end
            sbq.push_back((2 * NN)'(bam_model(32'(ra), 32'(rb), h, v, NN)));
            @(posedge clk); #1;
            ifr.in_valid = 1'b0;
            @(negedge clk);
            t = 0;
            while (!ifr.out_valid && t < 50) begin @(negedge clk); t++; end
            check($sformatf("reg N=%0d h=%0d v=%0d a=%0d b=%0d", NN, h, v, ra, rb),
                  64'(ifr.p), 64'(sbq.pop_front()));
            ifr.out_ready = 1'b1;
            @(posedge clk); #1;
            ifr.out_ready = 1'b0;
          end
      done = 1'b1;
    end
  end

  initial begin
    logic [7:0] ra, rb;
    int t;
    if8.in_valid = 1'b0; if8.out_ready = 1'b0;
    if8.a = '0; if8.b = '0; if8.cfg_h = '0; if8.cfg_v = '0;
    rst8 = 1'b1;
    repeat (2) @(negedge clk);
    rst8 = 1'b0;
    check("reset in_ready", 64'(if8.in_ready), 64'(1));
    check("reset out_valid", 64'(if8.out_valid), 64'(0));
    check("reset busy", 64'(if8.busy), 64'(0));
    check("reset p", 64'(if8.p), 64'(0));

    run_op8(8'd255, 8'd255, 4'd4, 4'd5, 16'd61184, 0, 1'b0, "h4v5_ff");
    run_op8(8'd200, 8'd100, 4'd0, 4'd0, 16'd20000, 0, 1'b0, "exact_200x100");
    run_op8(8'd1, 8'd16, 4'd4, 4'd5, 16'd0, 0, 1'b0, "h4v5_drop");
    run_op8(8'd2, 8'd16, 4'd4, 4'd5, 16'd32, 0, 1'b0, "h4v5_keep");
    run_op8(8'd173, 8'd91, 4'd8, 4'd0, 16'd0, 0, 1'b0, "h8");
    run_op8(8'd255, 8'd255, 4'd13, 4'd2, 16'd0, 0, 1'b0, "h13");
    run_op8(8'd128, 8'd128, 4'd0, 4'd14, 16'd16384, 0, 1'b0, "v14_top");
    run_op8(8'd255, 8'd255, 4'd0, 4'd15, 16'd16384, 0, 1'b0, "v15_sat");
    run_op8(8'd200, 8'd100, 4'd0, 4'd0, 16'd20000, 10, 1'b1, "bp_scramble");

    // Abandon an exact op during its 3rd RUN cycle.
    @(negedge clk);
    if8.a = 8'd99; if8.b = 8'd77; if8.cfg_h = 4'd0; if8.cfg_v = 4'd0; if8.in_valid = 1'b1;
    sb8.push_back(16'd7623);
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    check("midrst in_ready", 64'(if8.in_ready), 64'(1));
    check("midrst out_valid", 64'(if8.out_valid), 64'(0));
    check("midrst busy", 64'(if8.busy), 64'(0));
    check("midrst p", 64'(if8.p), 64'(0));
    void'(sb8.pop_back());
    run_op8(8'd3, 8'd5, 4'd0, 4'd0, 16'd15, 0, 1'b0, "after_rst");

    for (int k = 0; k < 1000; k++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      run_op8(ra, rb, 4'd0, 4'd0, 16'(ra) * 16'(rb), 0, 1'b0, "exact_rand");
    end
    for (int h = 0; h < 16; h++)
      for (int v = 0; v < 16; v++) begin
        ra = 8'($urandom); rb = 8'($urandom);
        run_op8(ra, rb, 4'(h), 4'(v), 16'(bam_model(32'(ra), 32'(rb), h, v, N)), 0, 1'b0,
                $sformatf("cfg h=%0d v=%0d", h, v));
      end

    t = 0;
    while (!(g_reg[0].done && g_reg[1].done) && t < 60000) begin @(negedge clk); t++; end
    check("regression finished", 64'(g_reg[0].done && g_reg[1].done), 64'(1));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
